// File: rtl/bitstream_store_ctrl.sv
// Bitstream store/reconfigure sequencer: bump-pointer region allocator, ID table and DMA read issue.
// Optional BSC_OVERWRITE_EN lets a store to an existing ID reuse its region when the new data fits.
module bitstream_store_ctrl #(
  parameter int                    ADDR_WIDTH  = 34,
  parameter int                    TABLE_DEPTH = 16,
  parameter logic [ADDR_WIDTH-1:0] MEM_BASE    = '0,
  parameter logic [ADDR_WIDTH-1:0] MEM_LIMIT   = 34'h4000_0000,
  parameter int                    ALIGN_BYTES = 64
) (
  input  logic                  s_axis_clk,
  input  logic                  rst,
  input  logic                  hdr_valid,
  output logic                  hdr_ready,
  input  logic [1:0]            hdr_func,
  input  logic [7:0]            hdr_id,
  input  logic [31:0]           hdr_size,
  input  logic                  hdr_size_valid,
  input  logic                  cap_bytes_valid,
  input  logic [7:0]            cap_bytes,
  input  logic                  cap_last,
  output logic [ADDR_WIDTH-1:0] axi_base_addr,
  output logic                  axi_base_addr_valid,
  output logic                  dma_cmd_valid,
  input  logic                  dma_cmd_ready,
  output logic [ADDR_WIDTH-1:0] dma_cmd_addr,
  output logic [31:0]           dma_cmd_len,
  output logic [7:0]            dma_cmd_id,
  input  logic                  dma_done,
  input  logic                  dma_err,
  output logic [ADDR_WIDTH-1:0] free_ptr,
  output logic                  busy,
  output logic                  err_valid,
  output logic [2:0]            err_code
);

  localparam int IDX_W = (TABLE_DEPTH > 1) ? $clog2(TABLE_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] ALIGN_M1 = (ADDR_WIDTH+1)'(ALIGN_BYTES - 1);

  localparam logic [2:0] ERR_NOSIZE  = 3'd1;
  localparam logic [2:0] ERR_BADID   = 3'd2;
  localparam logic [2:0] ERR_NOSPACE = 3'd3;
  localparam logic [2:0] ERR_SIZE    = 3'd4;
  localparam logic [2:0] ERR_NOENTRY = 3'd5;
  localparam logic [2:0] ERR_DMA     = 3'd6;
  localparam logic [2:0] ERR_FUNC    = 3'd7;

  typedef enum logic [2:0] {
    IDLE, ALLOC, CAPTURE, COMMIT, LOOKUP, DMA_CMD, DMA_WAIT, ERROR
  } state_t;

  // state is the observable FSM state for external checkers.
  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // the producer holds its payload stable while valid is high and ready is low.
  state_t state;

  logic [7:0]            id_q;
  logic [31:0]           size_q;
  logic                  size_valid_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [31:0]           remaining_q;
  logic                  reuse_q;

  logic [TABLE_DEPTH-1:0] tbl_valid;
  logic [ADDR_WIDTH-1:0]  tbl_base [TABLE_DEPTH];
  logic [31:0]            tbl_size [TABLE_DEPTH];

  logic [IDX_W-1:0]    idx;
  logic                id_ok;
  logic [ADDR_WIDTH:0] rsize_new;
  logic [ADDR_WIDTH:0] end_addr;
  logic [31:0]         rem_after;

  assign idx       = id_q[IDX_W-1:0];
  assign id_ok     = ({24'b0, id_q} < 32'(TABLE_DEPTH));
  assign rsize_new = ({{(ADDR_WIDTH+1-32){1'b0}}, size_q} + ALIGN_M1) & ~ALIGN_M1;
  assign end_addr  = {1'b0, free_ptr} + rsize_new;
  assign rem_after = remaining_q - {24'b0, cap_bytes};
  assign busy      = (state != IDLE);

`ifdef BSC_OVERWRITE_EN
  logic [ADDR_WIDTH:0] old_rsize;
  assign old_rsize = ({{(ADDR_WIDTH+1-32){1'b0}}, tbl_size[idx]} + ALIGN_M1) & ~ALIGN_M1;
`endif

  always_ff @(posedge s_axis_clk) begin
    if (rst) begin
      state               <= IDLE;
      hdr_ready           <= 1'b0;
      id_q                <= '0;
      size_q              <= '0;
      size_valid_q        <= 1'b0;
      base_q              <= '0;
      remaining_q         <= '0;
      reuse_q             <= 1'b0;
      free_ptr            <= MEM_BASE;
      tbl_valid           <= '0;
      axi_base_addr       <= '0;
      axi_base_addr_valid <= 1'b0;
      dma_cmd_valid       <= 1'b0;
      dma_cmd_addr        <= '0;
      dma_cmd_len         <= '0;
      dma_cmd_id          <= '0;
      err_valid           <= 1'b0;
      err_code            <= '0;
    end else begin
      axi_base_addr_valid <= 1'b0;
      err_valid           <= 1'b0;
      case (state)
        IDLE: begin
          hdr_ready <= 1'b1;
          if (hdr_valid && hdr_ready) begin
            hdr_ready    <= 1'b0;
            id_q         <= hdr_id;
            size_q       <= hdr_size;
            size_valid_q <= hdr_size_valid;
            if (hdr_func == 2'b00)      state <= ALLOC;
            else if (hdr_func == 2'b01) state <= LOOKUP;
            else begin
              err_valid <= 1'b1;
              err_code  <= ERR_FUNC;
              state     <= ERROR;
            end
          end
        end
        ALLOC: begin
          if (!size_valid_q || size_q == 32'd0) begin
            err_valid <= 1'b1;
            err_code  <= ERR_NOSIZE;
            state     <= ERROR;
          end else if (!id_ok) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BADID;
            state     <= ERROR;
`ifdef BSC_OVERWRITE_EN
          end else if (tbl_valid[idx] && rsize_new <= old_rsize) begin
            base_q              <= tbl_base[idx];
            axi_base_addr       <= tbl_base[idx];
            axi_base_addr_valid <= 1'b1;
            remaining_q         <= size_q;
            reuse_q             <= 1'b1;
            state               <= CAPTURE;
`else
          end else if (tbl_valid[idx]) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BADID;
            state     <= ERROR;
`endif
          end else if (end_addr > {1'b0, MEM_LIMIT}) begin
            err_valid <= 1'b1;
            err_code  <= ERR_NOSPACE;
            state     <= ERROR;
          end else begin
`ifdef BSC_OVERWRITE_EN
            tbl_valid[idx]      <= 1'b0;  // larger rewrite drops the old region
`endif
            base_q              <= free_ptr;
            axi_base_addr       <= free_ptr;
            axi_base_addr_valid <= 1'b1;
            remaining_q         <= size_q;
            reuse_q             <= 1'b0;
            state               <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (cap_bytes_valid) begin
            if ({24'b0, cap_bytes} > remaining_q) begin
              err_valid <= 1'b1;
              err_code  <= ERR_SIZE;
              state     <= ERROR;
            end else begin
              remaining_q <= rem_after;
              if (cap_last) begin
                if (rem_after == 32'd0) state <= COMMIT;
                else begin
                  err_valid <= 1'b1;
                  err_code  <= ERR_SIZE;
                  state     <= ERROR;
                end
              end
            end
          end
        end
        COMMIT: begin
          tbl_valid[idx] <= 1'b1;
          if (!reuse_q) free_ptr <= free_ptr + rsize_new[ADDR_WIDTH-1:0];
          hdr_ready <= 1'b1;
          state     <= IDLE;
        end
        LOOKUP: begin
          if (!id_ok) begin
            err_valid <= 1'b1;
            err_code  <= ERR_BADID;
            state     <= ERROR;
          end else if (!tbl_valid[idx]) begin
            err_valid <= 1'b1;
            err_code  <= ERR_NOENTRY;
            state     <= ERROR;
          end else begin
            dma_cmd_addr  <= tbl_base[idx];
            dma_cmd_len   <= tbl_size[idx];
            dma_cmd_id    <= id_q;
            dma_cmd_valid <= 1'b1;
            state         <= DMA_CMD;
          end
        end
        DMA_CMD: begin
          if (dma_cmd_ready) begin
            dma_cmd_valid <= 1'b0;
            state         <= DMA_WAIT;
          end
        end
        DMA_WAIT: begin
          if (dma_err) begin
            err_valid <= 1'b1;
            err_code  <= ERR_DMA;
            state     <= ERROR;
          end else if (dma_done) begin
            hdr_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        ERROR: begin
          err_code  <= '0;
          hdr_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Table payload needs no reset; tbl_valid gates every read.
  always_ff @(posedge s_axis_clk) begin
    if (state == COMMIT) begin
      tbl_base[idx] <= base_q;
      tbl_size[idx] <= size_q;
    end
  end

endmodule

// File: tb/tb_bitstream_store_ctrl.sv
// Directed bench for bitstream_store_ctrl with a 256-byte window to reach the NOSPACE boundary.
module tb_bitstream_store_ctrl;

  localparam int AW = 34;

  logic          s_axis_clk = 1'b0;
  logic          rst = 1'b1;
  logic          hdr_valid = 1'b0;
  logic          hdr_ready;
  logic [1:0]    hdr_func = '0;
  logic [7:0]    hdr_id = '0;
  logic [31:0]   hdr_size = '0;
  logic          hdr_size_valid = 1'b0;
  logic          cap_bytes_valid = 1'b0;
  logic [7:0]    cap_bytes = '0;
  logic          cap_last = 1'b0;
  logic [AW-1:0] axi_base_addr;
  logic          axi_base_addr_valid;
  logic          dma_cmd_valid;
  logic          dma_cmd_ready = 1'b0;
  logic [AW-1:0] dma_cmd_addr;
  logic [31:0]   dma_cmd_len;
  logic [7:0]    dma_cmd_id;
  logic          dma_done = 1'b0;
  logic          dma_err = 1'b0;
  logic [AW-1:0] free_ptr;
  logic          busy;
  logic          err_valid;
  logic [2:0]    err_code;

  int total = 0;
  int bad   = 0;

  bitstream_store_ctrl #(
    .ADDR_WIDTH(AW), .TABLE_DEPTH(16), .MEM_BASE(34'h0),
    .MEM_LIMIT(34'h100), .ALIGN_BYTES(64)
  ) dut (
    .s_axis_clk(s_axis_clk), .rst(rst),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_func(hdr_func),
    .hdr_id(hdr_id), .hdr_size(hdr_size), .hdr_size_valid(hdr_size_valid),
    .cap_bytes_valid(cap_bytes_valid), .cap_bytes(cap_bytes), .cap_last(cap_last),
    .axi_base_addr(axi_base_addr), .axi_base_addr_valid(axi_base_addr_valid),
    .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready),
    .dma_cmd_addr(dma_cmd_addr), .dma_cmd_len(dma_cmd_len), .dma_cmd_id(dma_cmd_id),
    .dma_done(dma_done), .dma_err(dma_err),
    .free_ptr(free_ptr), .busy(busy), .err_valid(err_valid), .err_code(err_code)
  );

  // Clock / reset
  always #5 s_axis_clk = ~s_axis_clk;

  task automatic tick();
    @(posedge s_axis_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_hdr(input logic [1:0] f, input logic [7:0] id,
                          input logic [31:0] sz, input logic sv);
    int n = 0;
    while (!hdr_ready && n < 20) begin
      tick();
      n++;
    end
    check("hdr_ready_wait", hdr_ready, 1);
    hdr_valid = 1'b1; hdr_func = f; hdr_id = id; hdr_size = sz; hdr_size_valid = sv;
    tick();
    hdr_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] n, input logic last);
    cap_bytes_valid = 1'b1; cap_bytes = n; cap_last = last;
    tick();
    cap_bytes_valid = 1'b0; cap_last = 1'b0;
  endtask

  task automatic wait_err(input string tag, input logic [2:0] code);
    int n = 0;
    while (!err_valid && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_seen"}, err_valid, 1);
    check(tag, err_code, code);
    check({tag, "_no_dma"}, dma_cmd_valid, 0);
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_hdr_ready", hdr_ready, 0);
    check("rst_free_ptr", free_ptr, 0);
    check("rst_busy", busy, 0);
    check("rst_err_valid", err_valid, 0);
    check("rst_err_code", err_code, 0);
    check("rst_dma_valid", dma_cmd_valid, 0);
    check("rst_base_valid", axi_base_addr_valid, 0);
    rst = 1'b0;
    tick();
    check("idle_hdr_ready", hdr_ready, 1);

    // Store id 3, 100 bytes in one last beat
    send_hdr(2'b00, 8'd3, 32'd100, 1'b1);
    check("s3_pulse_early", axi_base_addr_valid, 0);
    check("s3_busy", busy, 1);
    tick();
    check("s3_pulse", axi_base_addr_valid, 1);
    check("s3_base", axi_base_addr, 0);
    beat(8'd100, 1'b1);
    check("s3_pulse_end", axi_base_addr_valid, 0);
    tick();
    check("s3_free_ptr", free_ptr, 128);
    check("s3_idle", busy, 0);

    // Store id 4, 64 bytes, beats 40 then 30 overflow
    send_hdr(2'b00, 8'd4, 32'd64, 1'b1);
    tick();
    check("s4_base", axi_base_addr, 128);
    beat(8'd40, 1'b0);
    check("s4_no_err_yet", err_valid, 0);
    beat(8'd30, 1'b1);
    wait_err("s4_size", 3'd4);
    check("s4_free_ptr", free_ptr, 128);

    // Short frame: 64 expected, last after 32
    send_hdr(2'b00, 8'd4, 32'd64, 1'b1);
    tick();
    beat(8'd32, 1'b1);
    wait_err("short_size", 3'd4);

    // Reconfigure id 3 with DMA stalled for 5 cycles
    send_hdr(2'b01, 8'd3, 32'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("rc3_valid", dma_cmd_valid, 1);
      check("rc3_addr", dma_cmd_addr, 0);
      check("rc3_len", dma_cmd_len, 100);
      check("rc3_id", dma_cmd_id, 3);
      tick();
    end
    dma_cmd_ready = 1'b1;
    tick();
    dma_cmd_ready = 1'b0;
    check("rc3_valid_drop", dma_cmd_valid, 0);
    check("rc3_wait_busy", busy, 1);
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check("rc3_done_idle", busy, 0);
    check("rc3_no_err", err_valid, 0);

    // Reconfigure id 3, done and err together: err wins
    dma_cmd_ready = 1'b1;
    send_hdr(2'b01, 8'd3, 32'd0, 1'b0);
    tick();
    check("rc3b_valid", dma_cmd_valid, 1);
    tick();
    dma_cmd_ready = 1'b0;
    dma_done = 1'b1; dma_err = 1'b1;
    tick();
    dma_done = 1'b0; dma_err = 1'b0;
    wait_err("dma_err", 3'd6);

    // Error sweep
    send_hdr(2'b01, 8'd9, 32'd0, 1'b0);
    wait_err("noentry", 3'd5);
    send_hdr(2'b00, 8'd1, 32'd50, 1'b0);
    wait_err("nosize", 3'd1);
    send_hdr(2'b00, 8'd1, 32'd0, 1'b1);
    wait_err("zerosize", 3'd1);
    send_hdr(2'b00, 8'd20, 32'd50, 1'b1);
    wait_err("badid", 3'd2);
    send_hdr(2'b01, 8'd16, 32'd0, 1'b0);
    wait_err("rc_badid", 3'd2);
    send_hdr(2'b10, 8'd1, 32'd50, 1'b1);
    wait_err("func", 3'd7);
    send_hdr(2'b00, 8'd3, 32'd50, 1'b1);
    wait_err("dup_id", 3'd2);
    check("dup_free_ptr", free_ptr, 128);

    // Fresh window: 200 fills it exactly, 100 then has no space
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_free_ptr", free_ptr, 0);
    send_hdr(2'b00, 8'd1, 32'd200, 1'b1);
    tick();
    check("s1_pulse", axi_base_addr_valid, 1);
    check("s1_base", axi_base_addr, 0);
    beat(8'd200, 1'b1);
    tick();
    check("s1_free_ptr", free_ptr, 256);
    send_hdr(2'b00, 8'd2, 32'd100, 1'b1);
    wait_err("nospace", 3'd3);
    check("nospace_free_ptr", free_ptr, 256);
    send_hdr(2'b01, 8'd3, 32'd0, 1'b0);
    wait_err("rst_cleared_tbl", 3'd5);

    // Reset in the middle of a capture
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send_hdr(2'b00, 8'd6, 32'd64, 1'b1);
    tick();
    check("s6_pulse", axi_base_addr_valid, 1);
    beat(8'd32, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_free_ptr", free_ptr, 0);
    check("midrst_busy", busy, 0);
    send_hdr(2'b01, 8'd6, 32'd0, 1'b0);
    wait_err("midrst_noentry", 3'd5);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
